// File: rtl/halflife_meter_if.sv
// Bundle for the half-life meter: measurement control and level inputs in,
// status and result outputs back. meas_state mirrors the FSM for checkers.
interface halflife_meter_if #(
  parameter int CNT_W = 16
);
  // start/abort are level-sampled requests with no ready handshake: start is
  // taken on any edge where the meter is idle and abort is low, abort acts on
  // the next edge, and results are qualified by valid with a done pulse.
  logic             start;
  logic             abort;
  logic [3:0]       level;
  logic             busy;
  logic             done;
  logic             valid;
  logic             overflow;
  logic [CNT_W-1:0] period;
  logic [3:0]       ref_level;
  logic             meas_state;

  modport master (
    output start, abort, level,
    input  busy, done, valid, overflow, period, ref_level, meas_state
  );

  modport slave (
    input  start, abort, level,
    output busy, done, valid, overflow, period, ref_level, meas_state
  );
endinterface

// File: rtl/halflife_meter.sv
// Measures how many cycles a monitored level takes to fall to half of its
// reference value, with rebasing on rises and a stability filter on the drop.
module halflife_meter #(
  parameter int CNT_W  = 16,
  parameter int STABLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  halflife_meter_if.slave  bus
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       STABLE_L = 3'(STABLE);

  state_t           state, state_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             valid_q, valid_n;
  logic             ovf_q, ovf_n;
  logic [CNT_W-1:0] period_q, period_n;
  logic [3:0]       ref_q, ref_n;
  logic [3:0]       thr_q, thr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       run_len_q, run_len_n;
  logic [CNT_W-1:0] run_start_q, run_start_n;

  logic [CNT_W-1:0] cnt_sat;
  logic             cnt_full;
  logic             is_low;
  logic             is_high;
  logic [2:0]       run_inc;
  logic             finish;

  assign cnt_full = (cnt_q == CNT_MAX);
  assign cnt_sat  = cnt_full ? CNT_MAX : cnt_q + CNT_W'(1);
  assign is_low   = (bus.level <= thr_q);
  assign is_high  = (bus.level > ref_q);
  assign run_inc  = run_len_q + 3'd1;

  always_comb begin
    state_n     = state;
    busy_n      = busy_q;
    done_n      = 1'b0;
    valid_n     = valid_q;
    ovf_n       = ovf_q;
    period_n    = period_q;
    ref_n       = ref_q;
    thr_n       = thr_q;
    cnt_n       = cnt_q;
    run_len_n   = run_len_q;
    run_start_n = run_start_q;
    finish      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          ref_n       = bus.level;
          thr_n       = {1'b0, bus.level[3:1]};
          cnt_n       = '0;
          run_len_n   = '0;
          run_start_n = '0;
          ovf_n       = 1'b0;
          if (bus.level == 4'd0) begin
            // Nothing to halve: report a zero period without entering MEASURE.
            period_n = '0;
            valid_n  = 1'b1;
            done_n   = 1'b1;
          end else begin
            state_n = MEASURE;
            busy_n  = 1'b1;
            valid_n = 1'b0;
          end
        end
      end

      MEASURE: begin
        cnt_n = cnt_sat;
        if (bus.abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          valid_n = 1'b0;
        end else if (is_high) begin
          // Level rose above the reference: restart timing from the new peak.
          ref_n     = bus.level;
          thr_n     = {1'b0, bus.level[3:1]};
          cnt_n     = '0;
          run_len_n = '0;
        end else begin
          if (is_low) begin
            run_len_n = run_inc;
            if (run_len_q == 3'd0) run_start_n = cnt_sat;
          end else begin
            run_len_n = '0;
          end

          if (is_low && (run_inc == STABLE_L)) begin
            period_n = (run_len_q == 3'd0) ? cnt_sat : run_start_q;
            ovf_n    = 1'b0;
            finish   = 1'b1;
          end else if (cnt_full) begin
            period_n = CNT_MAX;
            ovf_n    = 1'b1;
            finish   = 1'b1;
          end
        end

        if (finish) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          valid_n = 1'b1;
          done_n  = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      period_q    <= '0;
      ref_q       <= '0;
      thr_q       <= '0;
      cnt_q       <= '0;
      run_len_q   <= '0;
      run_start_q <= '0;
    end else begin
      busy_q      <= busy_n;
      done_q      <= done_n;
      valid_q     <= valid_n;
      ovf_q       <= ovf_n;
      period_q    <= period_n;
      ref_q       <= ref_n;
      thr_q       <= thr_n;
      cnt_q       <= cnt_n;
      run_len_q   <= run_len_n;
      run_start_q <= run_start_n;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.valid      = valid_q;
  assign bus.overflow   = ovf_q;
  assign bus.period     = period_q;
  assign bus.ref_level  = ref_q;
  assign bus.meas_state = (state == MEASURE);

endmodule

// File: tb/tb_halflife_meter.sv
// Bench for halflife_meter: a 16-bit and a 4-bit counter instance share the
// same stimulus; completed results are scored against an expected queue.
module tb_halflife_meter;

  localparam int EW = 23;

  logic clk;
  logic rst_n;
  logic start_s;
  logic abort_m;
  logic abort_4;
  logic [3:0] lvl_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp4_q[$];

  halflife_meter_if #(.CNT_W(16)) bm ();
  halflife_meter_if #(.CNT_W(4))  b4 ();

  assign bm.start = start_s;
  assign bm.abort = abort_m;
  assign bm.level = lvl_s;
  assign b4.start = start_s;
  assign b4.abort = abort_4;
  assign b4.level = lvl_s;

  halflife_meter #(.CNT_W(16), .STABLE(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bm)
  );

  halflife_meter #(.CNT_W(4), .STABLE(2)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_res(input logic v, input logic b, input logic o,
                                             input logic [3:0] r, input logic [15:0] p);
    return {v, b, o, r, p};
  endfunction

  function automatic logic [EW-1:0] pack_m();
    return pack_res(bm.valid, bm.busy, bm.overflow, bm.ref_level, bm.period);
  endfunction

  function automatic logic [EW-1:0] pack_4();
    return pack_res(b4.valid, b4.busy, b4.overflow, b4.ref_level, {12'b0, b4.period});
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] l0);
    lvl_s   = l0;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
  endtask

  task automatic hold(input logic [3:0] l, input int n);
    lvl_s = l;
    repeat (n) step();
  endtask

  task automatic set_abort(input logic a);
    abort_m = a;
    abort_4 = a;
  endtask

  task automatic expect_both(input logic o, input logic [3:0] r, input logic [15:0] p);
    exp_q.push_back(pack_res(1'b1, 1'b0, o, r, p));
    exp4_q.push_back(pack_res(1'b1, 1'b0, o, r, p));
  endtask

  // scoreboard: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bm.done) begin
      if (exp_q.size() == 0) check("unexp_done_m", {31'b0, bm.done}, 32'd0);
      else                   check("result_m", 32'(pack_m()), 32'(exp_q.pop_front()));
    end
    if (rst_n && b4.done) begin
      if (exp4_q.size() == 0) check("unexp_done_4", {31'b0, b4.done}, 32'd0);
      else                    check("result_4", 32'(pack_4()), 32'(exp4_q.pop_front()));
    end
  end

  initial begin
    int lv;
    int n;
    start_s = 1'b0;
    set_abort(1'b0);
    lvl_s = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m", 32'(pack_m()), 32'd0);
    check("rst_4", 32'(pack_4()), 32'd0);
    check("rst_done", {31'b0, bm.done}, 32'd0);
    rst_n = 1'b1;
    step();

    // basic halving: drop to 4 at E5, stable at E6
    expect_both(1'b0, 4'd8, 16'd5);
    do_start(4'd8);
    check("busy_on", {31'b0, bm.busy}, 32'd1);
    check("state_dbg", {31'b0, bm.meas_state}, 32'd1);
    hold(4'd8, 4);
    hold(4'd4, 2);
    check("busy_off", {31'b0, bm.busy}, 32'd0);

    // glitch above threshold restarts the run (back-to-back start after done)
    expect_both(1'b0, 4'd9, 16'd7);
    do_start(4'd9);
    hold(4'd9, 2);
    hold(4'd4, 1);
    hold(4'd5, 1);
    hold(4'd9, 2);
    hold(4'd3, 2);
    check("period_glitch", {16'b0, bm.period}, 32'd7);

    // rebase on a rise above the reference
    expect_both(1'b0, 4'd10, 16'd3);
    do_start(4'd6);
    check("valid_clr", {31'b0, bm.valid}, 32'd0);
    hold(4'd6, 1);
    hold(4'd10, 3);
    hold(4'd5, 2);
    check("ref_rebase", {28'b0, bm.ref_level}, 32'd10);

    // abort at E3: no done, valid low, period kept
    do_start(4'd8);
    hold(4'd8, 2);
    set_abort(1'b1);
    step();
    set_abort(1'b0);
    check("abort_busy", {31'b0, bm.busy}, 32'd0);
    check("abort_valid", {31'b0, bm.valid}, 32'd0);
    check("abort_period", {16'b0, bm.period}, 32'd3);
    hold(4'd8, 3);

    // abort wins over a completion on the same edge
    do_start(4'd8);
    hold(4'd4, 1);
    lvl_s = 4'd4;
    set_abort(1'b1);
    step();
    set_abort(1'b0);
    check("abort_prio_busy", {31'b0, bm.busy}, 32'd0);
    check("abort_prio_valid", {31'b0, bm.valid}, 32'd0);
    hold(4'd0, 3);

    // abort in IDLE blocks start
    lvl_s   = 4'd12;
    start_s = 1'b1;
    set_abort(1'b1);
    step();
    start_s = 1'b0;
    set_abort(1'b0);
    check("idle_abort_busy", {31'b0, bm.busy}, 32'd0);
    check("idle_abort_ref", {28'b0, bm.ref_level}, 32'd8);
    hold(4'd12, 2);

    // zero level completes immediately without MEASURE
    expect_both(1'b0, 4'd0, 16'd0);
    do_start(4'd0);
    check("lvl0_busy", {31'b0, bm.busy}, 32'd0);
    hold(4'd0, 3);
    check("lvl0_busy2", {31'b0, bm.busy}, 32'd0);

    // overflow on the 4-bit instance; the 16-bit one is aborted afterwards
    exp4_q.push_back(pack_res(1'b1, 1'b0, 1'b1, 4'd8, 16'd15));
    do_start(4'd8);
    hold(4'd8, 16);
    check("ovf_main_busy", {31'b0, bm.busy}, 32'd1);
    check("ovf_flag_4", {31'b0, b4.overflow}, 32'd1);
    abort_m = 1'b1;
    step();
    abort_m = 1'b0;
    check("ovf_main_abort", {31'b0, bm.busy}, 32'd0);
    check("ovf_hold_4", {31'b0, b4.overflow}, 32'd1);

    // random plateau length then a stable drop to half
    for (int i = 0; i < 6; i++) begin
      lv = $urandom_range(1, 15);
      n  = $urandom_range(0, 12);
      expect_both(1'b0, 4'(lv), 16'(n + 1));
      do_start(4'(lv));
      hold(4'(lv), n);
      hold(4'(lv >> 1), 2);
    end

    // asynchronous reset in the middle of a measurement
    do_start(4'd8);
    hold(4'd8, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_m", 32'(pack_m()), 32'd0);
    check("async_rst_4", 32'(pack_4()), 32'd0);
    check("async_rst_done", {31'b0, bm.done}, 32'd0);
    #2;
    rst_n = 1'b1;

    expect_both(1'b0, 4'd8, 16'd5);
    do_start(4'd8);
    hold(4'd8, 4);
    hold(4'd4, 2);
    hold(4'd0, 4);

    check("pending_m", 32'(exp_q.size()), 32'd0);
    check("pending_4", 32'(exp4_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/halflife_meter.md
HALFLIFE_METER -- requirements
Module: halflife_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of the cycle counter and the period result; legal range 4..24.
REQ-002 Parameter STABLE, default 2, number of consecutive at-or-below-threshold samples needed to accept the halving; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request a measurement; sampled only in IDLE.
REQ-006 abort  input  1  cancel an active measurement.
REQ-007 level[3:0]  input  4  monitored count from the half-life timer, unsigned, sampled every cycle.
REQ-008 busy  output  1  high while in MEASURE.
REQ-009 done  output  1  one-cycle pulse when a measurement completes, normally or by overflow.
REQ-010 valid  output  1  period holds a completed result.
REQ-011 overflow  output  1  last completed measurement saturated.
REQ-012 period[CNT_W-1:0]  output  CNT_W  measured half-life in clk cycles.
REQ-013 ref_level[3:0]  output  4  reference level captured for the current or last measurement.

Function
REQ-014 All outputs are registered; no combinational path exists from any input to any output.
REQ-015 FSM has two states, IDLE and MEASURE; there are no other states.
REQ-016 IDLE with start=1 and abort=0 at edge E0 captures ref_level=level, threshold=level>>1 (floor), and clears cnt, run_len and run_start.
REQ-017 If the level captured at E0 is 0, the block completes at E0: period=0, valid=1, overflow=0, done=1 for one cycle, and the FSM stays in IDLE.
REQ-018 Otherwise E0 enters MEASURE, busy=1, and clears valid and overflow.
REQ-019 MEASURE, edge Ek (k=1,2,...): cnt becomes k, saturating at 2^CNT_W-1.
REQ-020 At Ek, level<=threshold increments run_len; when run_len was 0, run_start becomes k.
REQ-021 At Ek, level>threshold and level<=ref_level clears run_len.
REQ-022 At Ek, level>ref_level rebases: ref_level=level, threshold=level>>1, cnt=0, run_len=0; measurement continues.
REQ-023 When run_len reaches STABLE at Ek: period=run_start, valid=1, overflow=0, done=1 for the following cycle, FSM goes to IDLE, busy=0.
REQ-024 When cnt would exceed 2^CNT_W-1 without completion: period=all-ones, overflow=1, valid=1, done=1, FSM goes to IDLE.
REQ-025 Completion takes priority over overflow in the same cycle.
REQ-026 abort=1 in MEASURE goes to IDLE at the next edge: busy=0, valid=0, no done pulse, period unchanged.
REQ-027 abort has priority over completion, overflow and rebase in the same cycle.
REQ-028 abort=1 in IDLE blocks start that cycle and leaves all other state unchanged.
REQ-029 start is ignored in MEASURE.
REQ-030 A new start from IDLE is accepted on the cycle immediately after done.
REQ-031 period, valid, overflow and ref_level hold their values in IDLE until the next accepted start.

Reset
REQ-032 rst_n=0 asynchronously forces: IDLE, busy=0, done=0, valid=0, overflow=0, period=0, ref_level=0, cnt=0, run_len=0, run_start=0, threshold=0.
REQ-033 Reset asserted during MEASURE abandons the measurement with no done pulse.
REQ-034 The first start is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 STABLE=2: start with level=8; level=8 at E1..E4, level=4 at E5 and E6 -> period=5, valid=1, done pulses once, busy=0.
REQ-036 STABLE=2: level=9 (threshold 4); level=4 at E3, level=5 at E4, level=3 at E7 and E8 -> period=7 (run restarts after the glitch).
REQ-037 Start at level=6; level=10 at E2 (rebase, threshold 5); level=5 at E5 and E6 -> ref_level=10, period=3.
REQ-038 CNT_W=4: start at level=8 with level held at 8 -> done with overflow=1, period=15, valid=1.
REQ-039 Start at level=0 -> immediate done, period=0, busy never asserted; separately, abort at E3 -> no done, valid=0, busy=0.
REQ-040 rst_n pulsed low mid-MEASURE, asynchronous to clk -> outputs reach their reset values immediately; start after release measures correctly.
